// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: constants shared by the data-memory arbiter, the memory model
// and the Micro_MIPS integration.
//   ADDR_W / DATA_W    : data-memory address and data widths
//   S_PIPE/S_EXT/S_ACK : arbiter state encoding (2'd3 is unused, decodes as S_PIPE)
//   cnt_width()        : bits needed to hold a counter saturating at max_val
package mem_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  localparam logic [1:0] S_PIPE = 2'd0;
  localparam logic [1:0] S_EXT  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// arb_wait_cnt: saturating starvation counter for the memory arbiter.
// Counts the cycles an external request has been blocked by pipeline traffic.
//   reloj  in   clock
//   resetM in   synchronous active-high reset
//   clr    in   clear (has priority over inc)
//   inc    in   increment, saturating at WAIT_MAX
//   cnt    out  current count
module arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter int WAIT_MAX = 3,
  parameter int W        = cnt_width(WAIT_MAX)
) (
  input  logic         reloj,
  input  logic         resetM,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(WAIT_MAX);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // its inputs as they were before the edge, independent of block ordering.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX_V) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbitrates the single data-memory port between the pipeline MEM
// stage (zero-latency owner by default) and an external loader/debug port.
// An external request is granted when the pipeline is idle, or forced through
// after WAIT_MAX blocked cycles; the grant costs one S_EXT cycle (pipeline
// stalled if active) followed by one S_ACK cycle that always goes back to the
// pipeline.
//   reloj, resetM                 clock, synchronous active-high reset
//   pipe_rd/wr/wh/dir/di, pipe_do MEM-stage request and read data
//   stall                         pipeline freeze (S_EXT with pipeline active)
//   ext_req/we/wh/dir/di          external request (held stable until ext_ack)
//   ext_ack, ext_do               one-cycle completion pulse and read data
//   mem_rd/wr/wh/dir/di, mem_do   data-memory port (async read, sync write)
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int WAIT_MAX = 3
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              pipe_rd,
  input  logic              pipe_wr,
  input  logic              pipe_wh,
  input  logic [ADDR_W-1:0] pipe_dir,
  input  logic [DATA_W-1:0] pipe_di,
  output logic [DATA_W-1:0] pipe_do,
  output logic              stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_wh,
  input  logic [ADDR_W-1:0] ext_dir,
  input  logic [DATA_W-1:0] ext_di,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_do,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_wh,
  output logic [ADDR_W-1:0] mem_dir,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do
);

  localparam int                CNT_W  = cnt_width(WAIT_MAX);
  localparam logic [CNT_W-1:0]  WAIT_V = CNT_W'(WAIT_MAX);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             in_ext;
  logic             in_ack;
  logic             in_pipe;
  logic             pipe_act;
  logic             go_ext;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             wr_raw;
  logic [CNT_W-1:0] wait_cnt;

  assign in_ext   = (state == S_EXT);
  assign in_ack   = (state == S_ACK);
  // The unused encoding 2'd3 falls into the pipeline-owner decode.
  assign in_pipe  = ~in_ext & ~in_ack;
  assign pipe_act = pipe_rd | pipe_wr;
  assign go_ext   = in_pipe & ext_req & (~pipe_act | (wait_cnt == WAIT_V));

  // Count only while a request is actually being blocked; drop the count once
  // the requester gives up or is granted.
  assign cnt_clr  = go_ext | (in_pipe & ~ext_req);
  assign cnt_inc  = in_pipe & ext_req & pipe_act;

  arb_wait_cnt #(
    .WAIT_MAX (WAIT_MAX),
    .W        (CNT_W)
  ) u_wait_cnt (
    .reloj  (reloj),
    .resetM (resetM),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (wait_cnt)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nx = S_PIPE;
    if (in_ext) begin
      state_nx = S_ACK;
    end else if (in_ack) begin
      state_nx = S_PIPE;
    end else if (go_ext) begin
      state_nx = S_EXT;
    end
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      state   <= S_PIPE;
      ext_ack <= 1'b0;
      ext_do  <= '0;
    end else begin
      state   <= state_nx;
      ext_ack <= in_ext;
      if (in_ext && !ext_we) begin
        ext_do <= mem_do;
      end
    end
  end

  always_comb begin
    mem_rd  = pipe_rd;
    wr_raw  = pipe_wr;
    mem_wh  = pipe_wh;
    mem_dir = pipe_dir;
    mem_di  = pipe_di;
    if (in_ext) begin
      mem_rd  = ~ext_we;
      wr_raw  = ext_we;
      mem_wh  = ext_wh;
      mem_dir = ext_dir;
      mem_di  = ext_di;
    end
  end

  // Reset drops any write in flight, pipeline or external.
  assign mem_wr  = wr_raw & ~resetM;
  assign stall   = in_ext & pipe_act & ~resetM;
  assign pipe_do = mem_do;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios followed by randomized traffic, all checked
// cycle by cycle against a transaction-level reference model of the arbiter
// and a reference copy of the data memory.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int WAIT_MAX = 3;

  logic              reloj = 1'b0;
  logic              resetM;
  logic              pipe_rd, pipe_wr, pipe_wh;
  logic [ADDR_W-1:0] pipe_dir;
  logic [DATA_W-1:0] pipe_di, pipe_do;
  logic              stall;
  logic              ext_req, ext_we, ext_wh;
  logic [ADDR_W-1:0] ext_dir;
  logic [DATA_W-1:0] ext_di, ext_do;
  logic              ext_ack;
  logic              mem_rd, mem_wr, mem_wh;
  logic [ADDR_W-1:0] mem_dir;
  logic [DATA_W-1:0] mem_di, mem_do;

  always #5 reloj = ~reloj;

  mem_arb #(.WAIT_MAX(WAIT_MAX)) dut (
    .reloj(reloj), .resetM(resetM),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_wh(pipe_wh),
    .pipe_dir(pipe_dir), .pipe_di(pipe_di), .pipe_do(pipe_do), .stall(stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_wh(ext_wh),
    .ext_dir(ext_dir), .ext_di(ext_di), .ext_ack(ext_ack), .ext_do(ext_do),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wh(mem_wh),
    .mem_dir(mem_dir), .mem_di(mem_di), .mem_do(mem_do)
  );

  // Word write when wh = 1, low-half write otherwise.
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic wh);
    return wh ? d : {old_v[31:16], d[15:0]};
  endfunction

  // Data memory attached to the arbiter: asynchronous read, synchronous write.
  logic [31:0] mem_arr [128];
  always @(posedge reloj) if (mem_wr) mem_arr[mem_dir] <= merge(mem_arr[mem_dir], mem_di, mem_wh);
  assign mem_do = mem_arr[mem_dir];

  // Reference model: who owns the memory this cycle, how long the pending
  // external request has waited, and what the memory should contain.
  logic [31:0] ref_mem [128];
  bit          m_valid = 1'b0;
  bit          m_ext_turn, m_ack_turn;
  int          m_blocked;
  logic [31:0] m_ext_do;

  int          checks = 0;
  int          failures = 0;
  logic        o_ack, o_stall, o_wr;
  logic        prev_ack = 1'b0;
  logic [31:0] o_ext_do, o_pipe_do;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    logic        e_rd, e_wr, e_wh, e_stall;
    logic [6:0]  e_dir;
    logic [31:0] e_di;
    @(negedge reloj);
    o_ack = ext_ack; o_stall = stall; o_wr = mem_wr;
    o_ext_do = ext_do; o_pipe_do = pipe_do;
    if (m_valid) begin
      if (m_ext_turn) begin
        e_rd = ~ext_we; e_wr = ext_we; e_wh = ext_wh; e_dir = ext_dir; e_di = ext_di;
        e_stall = pipe_rd | pipe_wr;
      end else begin
        e_rd = pipe_rd; e_wr = pipe_wr; e_wh = pipe_wh; e_dir = pipe_dir; e_di = pipe_di;
        e_stall = 1'b0;
      end
      if (resetM) begin
        e_wr = 1'b0;
        e_stall = 1'b0;
      end
      check("mem_rd", 32'(mem_rd), 32'(e_rd));
      check("mem_wr", 32'(mem_wr), 32'(e_wr));
      check("mem_wh", 32'(mem_wh), 32'(e_wh));
      check("mem_dir", 32'(mem_dir), 32'(e_dir));
      check("mem_di", mem_di, e_di);
      check("stall", 32'(stall), 32'(e_stall));
      check("ext_ack", 32'(ext_ack), 32'(m_ack_turn));
      check("ext_do", ext_do, m_ext_do);
      check("ack_gap", 32'(ext_ack & prev_ack), 32'd0);
      if (!m_ext_turn) check("pipe_do", pipe_do, ref_mem[pipe_dir]);
    end
    prev_ack = ext_ack;
    @(posedge reloj);
    if (resetM) begin
      m_valid = 1'b1; m_ext_turn = 1'b0; m_ack_turn = 1'b0;
      m_blocked = 0; m_ext_do = '0;
    end else if (m_valid) begin
      if (m_ext_turn) begin
        if (ext_we) ref_mem[ext_dir] = merge(ref_mem[ext_dir], ext_di, ext_wh);
        else        m_ext_do = ref_mem[ext_dir];
        m_ext_turn = 1'b0;
        m_ack_turn = 1'b1;
      end else begin
        if (pipe_wr) ref_mem[pipe_dir] = merge(ref_mem[pipe_dir], pipe_di, pipe_wh);
        if (m_ack_turn) begin
          m_ack_turn = 1'b0;
        end else if (!ext_req) begin
          m_blocked = 0;
        end else if (!(pipe_rd | pipe_wr) || m_blocked >= WAIT_MAX) begin
          m_ext_turn = 1'b1;
          m_blocked = 0;
        end else begin
          m_blocked++;
        end
      end
    end
    #1;
  endtask

  // Step until ext_ack (bounded); lat is the index of the ack cycle, -1 on timeout.
  task automatic run_ext(output int lat, output int stalls, output int wrs);
    lat = -1; stalls = 0; wrs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      stalls += int'(o_stall);
      wrs    += int'(o_wr);
      if (o_ack === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int          lat, stalls, wrs, age;
    bit          ext_busy;
    logic [31:0] saved;
    int          op;

    for (int i = 0; i < 128; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    resetM = 1'b1;
    pipe_rd = 0; pipe_wr = 0; pipe_wh = 1; pipe_dir = '0; pipe_di = '0;
    ext_req = 0; ext_we = 0; ext_wh = 1; ext_dir = '0; ext_di = '0;

    // Reset state
    step(); step();
    resetM = 1'b0;
    step();
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_ext_do", o_ext_do, 32'd0);

    // Idle-pipeline external write
    ext_req = 1; ext_we = 1; ext_wh = 1; ext_dir = 7'h10; ext_di = 32'hDEADBEEF;
    run_ext(lat, stalls, wrs);
    ext_req = 0;
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_pulses", 32'(wrs), 32'd1);
    check("wr_stalls", 32'(stalls), 32'd0);

    // External read-back
    ext_req = 1; ext_we = 0;
    run_ext(lat, stalls, wrs);
    ext_req = 0;
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_data", o_ext_do, 32'hDEADBEEF);

    // Pipeline transparency
    pipe_rd = 1; pipe_dir = 7'h04;
    step();
    check("xpar_do", o_pipe_do, ref_mem[4]);
    check("xpar_stall", 32'(o_stall), 32'd0);
    pipe_dir = 7'h10;
    step();
    check("xpar_do_10", o_pipe_do, 32'hDEADBEEF);

    // Starvation under continuous pipeline reads
    pipe_dir = 7'h04;
    ext_req = 1; ext_we = 0; ext_dir = 7'h10;
    run_ext(lat, stalls, wrs);
    ext_req = 0;
    check("starve_latency", 32'(lat), 32'(WAIT_MAX + 2));
    check("starve_stalls", 32'(stalls), 32'd1);

    // Back-to-back requests with the pipeline active
    ext_req = 1; ext_we = 0; ext_dir = 7'h04;
    for (int t = 0; t < 3; t++) begin
      run_ext(lat, stalls, wrs);
      check("b2b_latency", 32'(lat), 32'(WAIT_MAX + 2));
      check("b2b_stalls", 32'(stalls), 32'd1);
    end
    ext_req = 0; pipe_rd = 0;

    // Reset during the S_EXT cycle of an external write
    saved = ref_mem[7'h20];
    ext_req = 1; ext_we = 1; ext_wh = 1; ext_dir = 7'h20; ext_di = 32'h1234_5678;
    step();
    resetM = 1;
    step();
    check("rst_mid_wr", 32'(o_wr), 32'd0);
    resetM = 0; ext_req = 0;
    step();
    check("rst_mid_ack", 32'(o_ack), 32'd0);
    check("rst_mid_ext_do", o_ext_do, 32'd0);
    pipe_rd = 1; pipe_dir = 7'h20;
    step();
    check("rst_mid_mem", o_pipe_do, saved);
    check("rst_mid_stall", 32'(o_stall), 32'd0);
    pipe_rd = 0;

    // Randomized traffic
    ext_busy = 0; age = 0; o_stall = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!ext_busy) begin
        ext_req = ($urandom_range(0, 2) == 0);
        ext_we  = 1'($urandom); ext_wh = 1'($urandom);
        ext_dir = 7'($urandom_range(0, 15)); ext_di = $urandom;
        ext_busy = ext_req; age = 0;
      end
      if (!o_stall) begin
        op = $urandom_range(0, 3);
        pipe_rd = (op == 1 || op == 2); pipe_wr = (op == 3);
        pipe_wh = 1'($urandom); pipe_dir = 7'($urandom_range(0, 15)); pipe_di = $urandom;
      end
      resetM = ($urandom_range(0, 199) == 0);
      step();
      if (ext_busy && o_ack === 1'b1) begin
        check("rand_lat_max", 32'(age <= WAIT_MAX + 2), 32'd1);
        ext_busy = 0;
      end else if (resetM) begin
        ext_busy = 0;
      end else if (ext_busy) begin
        age++;
        if (age > 30) begin
          check("rand_ack_timeout", 32'(age), 32'(WAIT_MAX + 2));
          ext_busy = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 3, giving the number of consecutive cycles an external request may be blocked by pipeline accesses before it is forced through.
REQ-002 SHALL have port reloj  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port resetM  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports pipe_rd, pipe_wr, pipe_wh  in  1 each  MEM-stage read strobe, write strobe and word/half select.
REQ-005 SHALL have ports pipe_dir  in  7  and pipe_di  in  32  MEM-stage address and write data.
REQ-006 SHALL have ports pipe_do  out  32  read data returned to the MEM stage, and stall  out  1  pipeline freeze request.
REQ-007 SHALL have ports ext_req, ext_we, ext_wh  in  1 each  external (loader/debug) request, write enable and word/half select.
REQ-008 SHALL have ports ext_dir  in  7  and ext_di  in  32  external address and write data.
REQ-009 SHALL have ports ext_ack  out  1  and ext_do  out  32  external completion pulse and read data.
REQ-010 SHALL have ports mem_rd, mem_wr, mem_wh  out  1 each, mem_dir  out  7, mem_di  out  32, mem_do  in  32  data-memory port (asynchronous read, synchronous write).

Function
REQ-011 SHALL implement a three-state FSM with states S_PIPE, S_EXT and S_ACK.
REQ-012 SHALL define pipe_act = pipe_rd | pipe_wr.
REQ-013 SHALL, in S_PIPE and S_ACK, drive mem_* combinationally from pipe_* and set pipe_do = mem_do, adding zero latency to the pipeline.
REQ-014 SHALL, in S_EXT, drive mem_rd = ~ext_we, mem_wr = ext_we, mem_wh = ext_wh, mem_dir = ext_dir and mem_di = ext_di.
REQ-015 SHALL go from S_PIPE to S_EXT when ext_req & (~pipe_act | wait_cnt == WAIT_MAX); otherwise it SHALL stay in S_PIPE.
REQ-016 SHALL always go from S_EXT to S_ACK, and from S_ACK to S_PIPE, after one cycle each.
REQ-017 SHALL keep a saturating counter wait_cnt that increments in S_PIPE when ext_req & pipe_act, clears on entering S_EXT, and clears in S_PIPE when ext_req = 0.
REQ-018 SHALL assert stall combinationally only in S_EXT with pipe_act = 1; the pipeline holds its request unchanged while stalled.
REQ-019 SHALL, at the end of S_EXT, register mem_do into ext_do when ext_we = 0, and hold ext_do unchanged otherwise.
REQ-020 SHALL assert ext_ack for exactly one cycle, in S_ACK; ext_do SHALL be valid in that cycle and SHALL hold until the next external read.
REQ-021 SHALL hold ext_req, ext_we, ext_wh, ext_dir and ext_di stable from request until ext_ack (requester obligation); ext_req still high after ack SHALL start a new transaction.
REQ-022 SHALL give minimum external latency of two cycles (req seen, then S_EXT, then ack in S_ACK) when the pipeline is idle.
REQ-023 SHALL give maximum external latency of WAIT_MAX+2 cycles under continuous pipeline traffic.
REQ-024 SHALL always give the pipeline the S_ACK cycle, so back-to-back external requests cannot starve the pipeline for more than one cycle in two.
REQ-025 SHALL ignore the value of ext_req during S_EXT and S_ACK.

Reset
REQ-026 SHALL, on a resetM-high clock edge, set state = S_PIPE, wait_cnt = 0, ext_ack = 0 and ext_do = 0.
REQ-027 SHALL force mem_wr = 0 in any cycle with resetM = 1, so an external or pipeline write in progress is dropped.
REQ-028 SHALL abort an external transaction that is cut by reset with no ext_ack; the requester must re-issue it.
REQ-029 SHALL hold stall = 0 while resetM = 1.

Structure
REQ-030 SHALL place the state encoding (S_PIPE = 2'd0, S_EXT = 2'd1, S_ACK = 2'd2) and the ADDR_W = 7 and DATA_W = 32 constants in a shared package, reused by mem and Micro_MIPS integration.
REQ-031 SHALL implement the saturating starvation counter as one sub-module, arb_wait_cnt; all other logic SHALL stay flat.
REQ-032 SHALL treat the unused state encoding 2'd3 as S_PIPE.

Verification
REQ-033 SHALL cover an idle-pipeline external write: ext_req = 1, ext_we = 1, ext_dir = 7'h10, ext_di = 32'hDEADBEEF -> mem_wr high for one cycle at 7'h10, ext_ack two cycles after req, stall = 0 throughout.
REQ-034 SHALL cover an external read-back: read of 7'h10 after the write above -> ext_do = 32'hDEADBEEF in the ext_ack cycle.
REQ-035 SHALL cover starvation: pipe_rd held high continuously, ext_req raised -> S_EXT reached after exactly 3 blocked cycles, stall = 1 for one cycle, ext_ack on the following cycle.
REQ-036 SHALL cover back-to-back requests: ext_req held high for 3 transactions with pipeline active -> pipeline owns the memory in every S_ACK cycle, and ext_ack is never asserted in consecutive cycles.
REQ-037 SHALL cover reset mid-transaction: resetM pulsed in the S_EXT cycle of an external write to 7'h20 -> memory at 7'h20 unchanged, no ext_ack, next state S_PIPE, ext_do = 0.
REQ-038 SHALL cover pipeline transparency: pipe_rd = 1 at pipe_dir = 7'h04 with no ext_req -> pipe_do equals memory contents in the same cycle, stall = 0.
